// File: rtl/stepper_move_ctrl.sv
// Two-requester stepper move controller: round-robin grant, tick-paced stepping toward a clamped target, hold, done.
// Compile-time option HALF_STEP_EN selects the 8-entry half-step coil sequence instead of the 4-entry full-step one.
module stepper_move_ctrl #(
  parameter int POS_W      = 12,
  parameter int MAX_POS    = 3200,
  parameter int STEP_DIV   = 100000,
  parameter int HOLD_TICKS = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [POS_W-1:0] tgt_a,
  input  logic [POS_W-1:0] tgt_b,
  input  logic             stop,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [3:0]       signal,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

`ifdef HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif
  localparam int TICK_W = $clog2(STEP_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(MAX_POS);

  typedef enum logic [2:0] {IDLE, GRANT, MOVE, HOLD, DONE} state_t;

  function automatic logic [3:0] coil_pattern(input logic [PH_W-1:0] ph);
`ifdef HALF_STEP_EN
    case (ph)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1100;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0010;
      3'd5:    return 4'b0011;
      3'd6:    return 4'b0001;
      default: return 4'b1001;
    endcase
`else
    case (ph)
      2'd0:    return 4'b1100;
      2'd1:    return 4'b0110;
      2'd2:    return 4'b0011;
      default: return 4'b1001;
    endcase
`endif
  endfunction

  state_t            state;
  logic              sel_b;
  logic              prio_b;
  logic [POS_W-1:0]  target;
  logic [PH_W-1:0]   phase;
  logic [TICK_W-1:0] tick_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic             tick;
  logic             pick_b;
  logic [POS_W-1:0] tgt_sel;

  // B wins only when A is absent or B holds the round-robin priority.
  assign pick_b  = req_b & (~req_a | prio_b);
  assign tick    = (tick_cnt == TICK_LAST);
  assign tgt_sel = sel_b ? tgt_b : tgt_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: target is reset too, so an interrupted move can never resume with a stale goal.
      state    <= IDLE;
      sel_b    <= 1'b0;
      prio_b   <= 1'b0;
      target   <= '0;
      position <= '0;
      phase    <= '0;
      tick_cnt <= '0;
      hold_cnt <= '0;
      signal   <= 4'b0000;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low with non-blocking writes; a later write in the case wins.
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            state  <= GRANT;
            sel_b  <= pick_b;
            prio_b <= ~pick_b;
            gnt_a  <= ~pick_b;
            gnt_b  <= pick_b;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          target   <= (tgt_sel > POS_MAX) ? POS_MAX : tgt_sel;
          tick_cnt <= '0;
          signal   <= coil_pattern(phase);
          state    <= MOVE;
        end
        MOVE: begin
          if (stop) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
            signal  <= 4'b0000;
          end else if (tick) begin
            tick_cnt <= '0;
            if (position < target) begin
              position <= position + POS_W'(1);
              phase    <= phase + PH_W'(1);
              signal   <= coil_pattern(phase + PH_W'(1));
            end else if (position > target) begin
              position <= position - POS_W'(1);
              phase    <= phase - PH_W'(1);
              signal   <= coil_pattern(phase - PH_W'(1));
            end else begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        HOLD: begin
          if (stop) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
            signal  <= 4'b0000;
          end else if (tick) begin
            tick_cnt <= '0;
            if (hold_cnt == HOLD_LAST) begin
              state  <= DONE;
              done   <= 1'b1;
              signal <= 4'b0000;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          signal <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl: directed vector table, random moves and reset corner cases.
// Expected waveforms come from move arithmetic (ticks elapsed, clamped distance), not from a state machine.
module tb_stepper_move_ctrl;
  localparam int POS_W      = 12;
  localparam int MAX_POS    = 3200;
  localparam int STEP_DIV   = 4;
  localparam int HOLD_TICKS = 2;
`ifdef HALF_STEP_EN
  localparam int N_PH = 8;
  localparam logic [3:0] SEQ [N_PH] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                         4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
  localparam int N_PH = 4;
  localparam logic [3:0] SEQ [N_PH] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_a = 1'b0, req_b = 1'b0, stop = 1'b0;
  logic [POS_W-1:0] tgt_a = '0, tgt_b = '0;
  logic             gnt_a, gnt_b, busy, done, aborted;
  logic [3:0]       signal;
  logic [POS_W-1:0] position;

  stepper_move_ctrl #(
    .POS_W(POS_W), .MAX_POS(MAX_POS), .STEP_DIV(STEP_DIV), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .tgt_a(tgt_a), .tgt_b(tgt_b),
    .stop(stop), .gnt_a(gnt_a), .gnt_b(gnt_b), .signal(signal), .position(position),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: where the motor is, which coil phase, and who was served last.
  int model_pos   = 0;
  int model_phase = 0;
  bit last_was_a  = 1'b0;

  typedef struct {
    logic             ra;
    logic             rb;
    logic [POS_W-1:0] ta;
    logic [POS_W-1:0] tb;
    int               stop_off;
    bit               early;
    bit               exp_b;
    int               exp_pos;
    bit               exp_ab;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_gnt_a"}, gnt_a, 0);
    check({tag, "_gnt_b"}, gnt_b, 0);
    check({tag, "_signal"}, signal, 0);
    check({tag, "_position"}, position, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
  endtask

  // One complete move; every cycle is compared against positions derived from elapsed ticks.
  task automatic do_move(input vec_t v, output bit won_b, output int fin_pos, output bit ab_seen);
    int tgt, d, dir, total, done_off, k, steps, ph, epos;
    bit exp_b, stopped, got;
    exp_b   = v.rb && (!v.ra || last_was_a);
    req_a   = v.ra;
    req_b   = v.rb;
    tgt_a   = v.ta;
    tgt_b   = v.tb;
    stop    = v.early;
    got     = 1'b0;
    won_b   = 1'b0;
    fin_pos = -1;
    ab_seen = 1'b0;
    epos    = model_pos;
    ph      = model_phase;
    for (int w = 0; w < 4 && !got; w++) begin
      @(posedge clk); #1;
      if (gnt_a || gnt_b) begin
        got = 1'b1;
        check("grant_latency", w, 0);
      end
    end
    check("grant_seen", got, 1);
    if (!got) begin
      req_a = 1'b0; req_b = 1'b0; stop = 1'b0;
      return;
    end
    won_b = gnt_b;
    check("gnt_a_pulse", gnt_a, !exp_b);
    check("gnt_b_pulse", gnt_b, exp_b);
    check("busy_grant", busy, 1);
    check("signal_grant", signal, 0);
    req_a = 1'b0;
    req_b = 1'b0;

    tgt = exp_b ? int'(v.tb) : int'(v.ta);
    if (tgt > MAX_POS) tgt = MAX_POS;
    d   = tgt - model_pos;
    dir = (d < 0) ? -1 : 1;
    if (d < 0) d = -d;
    total    = (d + 1 + HOLD_TICKS) * STEP_DIV;
    stopped  = (v.stop_off >= 0) && (v.stop_off < total);
    done_off = stopped ? v.stop_off + 1 : total;

    for (int o = 0; o <= done_off; o++) begin
      @(posedge clk); #1;
      k     = ((o == done_off) ? o - 1 : o) / STEP_DIV;
      steps = (k < d) ? k : d;
      epos  = model_pos + dir * steps;
      ph    = ((model_phase + dir * steps) % N_PH + N_PH) % N_PH;
      check("move_position", position, epos);
      check("move_busy", busy, 1);
      if (o == 0) begin
        check("gnt_a_one_cycle", gnt_a, 0);
        check("gnt_b_one_cycle", gnt_b, 0);
      end
      if (o < done_off) begin
        check("move_signal", signal, SEQ[ph]);
        check("move_done", done, 0);
        check("move_aborted", aborted, 0);
      end else begin
        check("done_pulse", done, 1);
        check("done_aborted", aborted, stopped);
        check("done_signal", signal, 0);
        fin_pos = int'(position);
        ab_seen = aborted;
      end
      stop = (o == v.stop_off) && (o < done_off);
    end
    stop = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_aborted", aborted, 0);
    check("idle_signal", signal, 0);
    model_pos   = epos;
    model_phase = ph;
    last_was_a  = !exp_b;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   wb, ab, got;
    int   fp, t, dones;

    //        ra    rb    ta         tb         stop early exp_b pos   ab
    vecs[0]  = '{1'b1, 1'b0, 12'd3,    12'd0,    -1, 1'b0, 1'b0, 3,    1'b0};
    vecs[1]  = '{1'b0, 1'b1, 12'd0,    12'd1,    -1, 1'b0, 1'b1, 1,    1'b0};
    vecs[2]  = '{1'b1, 1'b1, 12'd2,    12'd5,    -1, 1'b0, 1'b0, 2,    1'b0};
    vecs[3]  = '{1'b1, 1'b1, 12'd0,    12'd4,    -1, 1'b0, 1'b1, 4,    1'b0};
    vecs[4]  = '{1'b1, 1'b0, 12'd4,    12'd0,    -1, 1'b1, 1'b0, 4,    1'b0};
    vecs[5]  = '{1'b1, 1'b0, 12'd4000, 12'd0,    -1, 1'b0, 1'b0, 3200, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 12'd0,    12'd4000,  2, 1'b0, 1'b1, 3200, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 12'd0,    12'd0,     9, 1'b0, 1'b0, 3198, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 12'd0,    12'd3198,  6, 1'b0, 1'b1, 3198, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 12'd3190, 12'd10,   -1, 1'b0, 1'b0, 3190, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 12'd3195, 12'd3185, -1, 1'b0, 1'b1, 3185, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("after_reset_stop_idle");
    stop = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_move(vecs[i], wb, fp, ab);
      check($sformatf("v%0d_winner_b", i), wb, vecs[i].exp_b);
      check($sformatf("v%0d_final_pos", i), fp, vecs[i].exp_pos);
      check($sformatf("v%0d_aborted", i), ab, vecs[i].exp_ab);
    end

    for (int r = 0; r < 30; r++) begin
      v.ra = 1'($urandom_range(0, 1));
      v.rb = 1'($urandom_range(0, 1));
      if (!v.ra && !v.rb) v.ra = 1'b1;
      t = model_pos + int'($urandom_range(0, 24)) - 12;
      if (t < 0) t = 0;
      if (t > MAX_POS) t = MAX_POS;
      if (model_pos > 3150 && $urandom_range(0, 4) == 0) t = 4095;
      v.ta = POS_W'(t);
      t = model_pos + int'($urandom_range(0, 24)) - 12;
      if (t < 0) t = 0;
      if (t > MAX_POS) t = MAX_POS;
      v.tb = POS_W'(t);
      v.stop_off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1;
      v.early    = 1'($urandom_range(0, 1));
      v.exp_b    = 1'b0;
      v.exp_pos  = 0;
      v.exp_ab   = 1'b0;
      do_move(v, wb, fp, ab);
    end

    // Reset in the middle of a B move: outputs clear at once and no done ever follows.
    req_b = 1'b1;
    tgt_b = POS_W'((model_pos > 10) ? model_pos - 8 : model_pos + 8);
    got = 1'b0;
    for (int w = 0; w < 4 && !got; w++) begin
      @(posedge clk); #1;
      if (gnt_b) got = 1'b1;
    end
    check("rst_move_grant_b", got, 1);
    req_b = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("rst_move_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check_idle_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no_done_after_reset", dones, 0);
    check_idle_zero("post_reset_idle");
    model_pos   = 0;
    model_phase = 0;
    last_was_a  = 1'b0;

    v = '{1'b1, 1'b1, 12'd5, 12'd7, -1, 1'b0, 1'b0, 5, 1'b0};
    do_move(v, wb, fp, ab);
    check("post_reset_rr_favours_a", wb, 0);
    check("post_reset_final_pos", fp, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stepper_move_ctrl.md
STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 SHALL have parameter POS_W, default 12, position/target width in bits.
REQ-002 SHALL have parameter MAX_POS, default 3200, highest legal position in steps.
REQ-003 SHALL have parameter STEP_DIV, default 100000, clk cycles per motor step; legal range is 2 or more.
REQ-004 SHALL have parameter HOLD_TICKS, default 50, step periods the coils stay energised after arrival.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports req_a and req_b, input, 1 bit each: move request, held high until granted.
REQ-008 SHALL have ports tgt_a and tgt_b, input, POS_W bits each: target position, sampled at grant.
REQ-009 SHALL have ports gnt_a and gnt_b, output, 1 bit each: one-cycle grant pulse.
REQ-010 SHALL have port stop, input, 1 bit: abort the current move.
REQ-011 SHALL have port signal, output, 4 bits: coil drive pattern.
REQ-012 SHALL have port position, output, POS_W bits: current step count.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a move ends.
REQ-015 SHALL have port aborted, output, 1 bit: high with done when the move was ended by stop.

Function
REQ-016 SHALL implement the FSM states IDLE, GRANT, MOVE, HOLD and DONE.
REQ-017 In IDLE with any request, SHALL go to GRANT; if both requests are high, SHALL grant the requester not served last (round-robin), with A favoured after reset.
REQ-018 In GRANT, SHALL pulse the matching gnt_x for exactly one cycle, latch tgt_x clamped to MAX_POS, and go to MOVE on the next cycle.
REQ-019 Requests arriving while busy SHALL be ignored until IDLE; no request is lost while it is held high.
REQ-020 A tick counter SHALL count 0..STEP_DIV-1 in MOVE and HOLD; the tick fires on the wrap to 0; the counter SHALL clear on entry to MOVE, so the first tick comes STEP_DIV cycles after entry.
REQ-021 On a tick in MOVE: if position < target, position +1 and phase +1; if position > target, position -1 and phase -1; if equal, go to HOLD with position and phase unchanged.
REQ-022 Phase SHALL wrap modulo the sequence length; position SHALL never leave 0..MAX_POS.
REQ-023 signal SHALL be the phase pattern in MOVE and HOLD, and 4'b0000 in IDLE, GRANT and DONE.
REQ-024 Full-step patterns by phase 0..3 SHALL be 1100, 0110, 0011, 1001.
REQ-025 HOLD SHALL last HOLD_TICKS ticks, then go to DONE.
REQ-026 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-027 stop high in MOVE or HOLD SHALL go to DONE on the next cycle with aborted=1, keeping position and phase.
REQ-028 stop SHALL be ignored in IDLE and GRANT.
REQ-029 A target equal to the current position SHALL reach HOLD at the first tick.

Reset
REQ-030 rst low SHALL asynchronously force: state IDLE, position 0, phase 0, tick 0, round-robin pointer to A, signal 0, gnt_a/gnt_b/done/aborted/busy 0.
REQ-031 Reset mid-move SHALL discard the latched target; there SHALL be no done pulse.

Configuration
REQ-032 Macro HALF_STEP_EN SHALL select the step mode at compile time.
REQ-033 With HALF_STEP_EN defined, SHALL use an 8-entry phase sequence: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-034 With HALF_STEP_EN undefined, SHALL use the 4-entry full-step sequence of REQ-024; position always counts sequence steps.

Verification (STEP_DIV=4, HOLD_TICKS=2, MAX_POS=3200, full step unless noted)
REQ-035 Reset, then req_a with tgt_a=3 -> gnt_a one cycle; signal steps 1100, 0110, 0011, 1001 at 4-cycle spacing; position reaches 3; done after 2 hold ticks.
REQ-036 From position 3, tgt_b=1 -> position 3, 2, 1; phase runs backwards 1001, 0011, 0110; done=1, aborted=0.
REQ-037 req_a and req_b high together, twice in a row -> first gnt_a, then gnt_b.
REQ-038 tgt_a=4000 -> position stops at 3200; stop asserted mid-move -> done with aborted=1, signal 0, position retained.
REQ-039 HALF_STEP_EN defined, tgt_a=2 -> signal 1100, then 0100; position 2.
REQ-040 rst low mid-move -> all outputs 0 immediately; no done pulse after rst goes high.
